// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: owns the cipher state, round counter and result register.
// Byte k of every 128-bit bus sits at [127-8k -: 8]; byte 0 is the most significant byte.

module aes_mix_columns (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam int B = 127 - 32 * c;
    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_state[B      -: 8];
    assign w_a1 = i_state[B -  8 -: 8];
    assign w_a2 = i_state[B - 16 -: 8];
    assign w_a3 = i_state[B - 24 -: 8];

    assign o_state[B      -: 8] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_state[B -  8 -: 8] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
    assign o_state[B - 16 -: 8] = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
    assign o_state[B - 24 -: 8] = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
  end

endmodule

// state   | meaning
// S_IDLE  | waiting for start
// S_KEY0  | initial AddRoundKey with round key 0
// S_ROUND | full rounds 1..NR-1
// S_LAST  | final round (no MixColumns), writes ciphertext
// S_DONE  | one-cycle completion pulse
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [127:0] i_plaintext,
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_ciphertext,
  output logic         o_rk_req,
  output logic [3:0]   o_rk_idx,
  input  logic [127:0] i_round_key,
  input  logic         i_rk_valid,
  output logic [127:0] o_sbsr_in,
  input  logic [127:0] i_sbsr_out
);

  localparam logic [3:0] LP_NR    = 4'(NR);
  localparam logic [3:0] LP_NR_M1 = 4'(NR - 1);

  typedef enum logic [2:0] {S_IDLE, S_KEY0, S_ROUND, S_LAST, S_DONE} state_t;

  state_t       r_fsm, w_fsm_next;
  logic [127:0] r_aes_state;
  logic [3:0]   r_round;
  logic [127:0] r_ciphertext;
  logic [127:0] w_mix;
  logic         w_commit;

  aes_mix_columns u_mix (
    .i_state (i_sbsr_out),
    .o_state (w_mix)
  );

  assign w_commit     = o_rk_req & i_rk_valid;
  assign o_sbsr_in    = r_aes_state;
  assign o_ciphertext = r_ciphertext;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_fsm <= S_IDLE;
    else         r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    if (i_abort) begin
      w_fsm_next = S_IDLE;
    end else begin
      case (r_fsm)
        S_IDLE:  if (i_start) w_fsm_next = S_KEY0;
        S_KEY0:  if (w_commit) w_fsm_next = S_ROUND;
        S_ROUND: if (w_commit && r_round == LP_NR_M1) w_fsm_next = S_LAST;
        S_LAST:  if (w_commit) w_fsm_next = S_DONE;
        S_DONE:  w_fsm_next = S_IDLE;
        default: w_fsm_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy   = (r_fsm != S_IDLE);
    o_done   = 1'b0;
    o_rk_req = 1'b0;
    o_rk_idx = 4'd0;
    case (r_fsm)
      S_KEY0: begin
        o_rk_req = 1'b1;
      end
      S_ROUND: begin
        o_rk_req = 1'b1;
        o_rk_idx = r_round;
      end
      S_LAST: begin
        o_rk_req = 1'b1;
        o_rk_idx = LP_NR;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Abort clears the working state but leaves the last completed result visible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_aes_state  <= '0;
      r_round      <= '0;
      r_ciphertext <= '0;
    end else if (i_abort) begin
      r_aes_state <= '0;
      r_round     <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (i_start) begin
          r_aes_state <= i_plaintext;
          r_round     <= 4'd0;
        end
        S_KEY0: if (w_commit) begin
          r_aes_state <= r_aes_state ^ i_round_key;
          r_round     <= 4'd1;
        end
        S_ROUND: if (w_commit) begin
          r_aes_state <= w_mix ^ i_round_key;
          r_round     <= r_round + 4'd1;
        end
        S_LAST: if (w_commit) begin
          r_ciphertext <= i_sbsr_out ^ i_round_key;
        end
        default: ;
      endcase
    end
  end

endmodule
